// File: rtl/csr_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit_if
// Description : CSR access bus between the WB stage (master) and the CSR
//               register file (slave): read port, masked write port.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_unit_if;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;

  modport master (
    output csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    input  csr_rvalue
  );

  modport slave (
    input  csr_re, csr_num, csr_we, csr_wmask, csr_wvalue,
    output csr_rvalue
  );
endinterface
`default_nettype wire

// File: rtl/csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : csr_unit
// Description : LoongArch control/status register file. Masked csrrd/csrwr/
//               csrxchg port, exception entry/return bookkeeping, countdown
//               timer and interrupt aggregation.
//               Optional macro CSR_TID_EN adds the TID register at 0x40.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_unit #(
  parameter int SAVE_NUM = 4,
  parameter int HWI_NUM  = 8,
  parameter int TIMER_W  = 32
) (
  input  wire logic               clk,
  input  wire logic               reset,
  csr_unit_if.slave               csr,
  input  wire logic               wb_ex,
  input  wire logic [5:0]         wb_ecode,
  input  wire logic [8:0]         wb_esubcode,
  input  wire logic [31:0]        wb_pc,
  input  wire logic [31:0]        wb_vaddr,
  input  wire logic               eret_flush,
  input  wire logic [HWI_NUM-1:0] hw_int_in,
  input  wire logic               ipi_int_in,
  output logic                    has_int,
  output logic [31:0]             ex_entry,
  output logic [31:0]             era_out
);

  localparam logic [13:0] c_addr_crmd   = 14'h000;
  localparam logic [13:0] c_addr_prmd   = 14'h001;
  localparam logic [13:0] c_addr_ecfg   = 14'h004;
  localparam logic [13:0] c_addr_estat  = 14'h005;
  localparam logic [13:0] c_addr_era    = 14'h006;
  localparam logic [13:0] c_addr_badv   = 14'h007;
  localparam logic [13:0] c_addr_eentry = 14'h00C;
  localparam logic [13:0] c_addr_save   = 14'h030;
  localparam logic [13:0] c_addr_tid    = 14'h040;
  localparam logic [13:0] c_addr_tcfg   = 14'h041;
  localparam logic [13:0] c_addr_tval   = 14'h042;
  localparam logic [13:0] c_addr_ticlr  = 14'h044;
  localparam logic [5:0]  c_ecode_ade   = 6'h08;
  localparam logic [5:0]  c_ecode_ale   = 6'h09;
  // LIE bit 10 has no interrupt source behind it
  localparam logic [12:0] c_lie_mask    = 13'h1BFF;

  logic [1:0]         crmd_plv_q,   crmd_plv_d;
  logic               crmd_ie_q,    crmd_ie_d;
  logic [1:0]         prmd_pplv_q,  prmd_pplv_d;
  logic               prmd_pie_q,   prmd_pie_d;
  logic [12:0]        ecfg_lie_q,   ecfg_lie_d;
  logic [1:0]         is_sw_q,      is_sw_d;
  logic [HWI_NUM-1:0] is_hw_q,      is_hw_d;
  logic               is_timer_q,   is_timer_d;
  logic               is_ipi_q,     is_ipi_d;
  logic [5:0]         ecode_q,      ecode_d;
  logic [8:0]         esubcode_q,   esubcode_d;
  logic [31:0]        era_q,        era_d;
  logic [31:0]        badv_q,       badv_d;
  logic [25:0]        eentry_q,     eentry_d;
  logic [31:0]        save_q [SAVE_NUM];
  logic [31:0]        save_d [SAVE_NUM];
  logic [TIMER_W-1:0] tcfg_q,       tcfg_d;
  logic [TIMER_W-1:0] timer_q,      timer_d;
`ifdef CSR_TID_EN
  logic [31:0]        tid_q,        tid_d;
`endif

  logic [7:0]  w_hw_is;
  logic [12:0] w_is;
  logic [31:0] w_rdata;
  logic [31:0] w_wnew;

  // Place the hardware interrupt lines into the 8-bit IS[9:2] slot
  always_comb begin
    w_hw_is                = '0;
    w_hw_is[HWI_NUM-1:0]   = is_hw_q;
  end

  assign w_is = {is_ipi_q, is_timer_q, 1'b0, w_hw_is, is_sw_q};

  // Read mux: current value of the addressed CSR, independent of csr_re
  always_comb begin
    w_rdata = '0;
    case (csr.csr_num)
      c_addr_crmd:   w_rdata = {28'b0, 1'b1, crmd_ie_q, crmd_plv_q};
      c_addr_prmd:   w_rdata = {29'b0, prmd_pie_q, prmd_pplv_q};
      c_addr_ecfg:   w_rdata = {19'b0, ecfg_lie_q};
      c_addr_estat:  w_rdata = {1'b0, esubcode_q, ecode_q, 3'b0, w_is};
      c_addr_era:    w_rdata = era_q;
      c_addr_badv:   w_rdata = badv_q;
      c_addr_eentry: w_rdata = {eentry_q, 6'b0};
      c_addr_tcfg:   w_rdata = 32'(tcfg_q);
      c_addr_tval:   w_rdata = 32'(timer_q);
`ifdef CSR_TID_EN
      c_addr_tid:    w_rdata = tid_q;
`endif
      default:       w_rdata = '0;
    endcase
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (csr.csr_num == c_addr_save + 14'(i)) w_rdata = save_q[i];
    end
  end

  assign csr.csr_rvalue = csr.csr_re ? w_rdata : 32'h0;
  // Merged write value; each register keeps only its writable slice
  assign w_wnew = (csr.csr_wmask & csr.csr_wvalue) | (~csr.csr_wmask & w_rdata);

  // Next-state: software writes, exception entry/return, timer
  always_comb begin
    crmd_plv_d  = crmd_plv_q;
    crmd_ie_d   = crmd_ie_q;
    prmd_pplv_d = prmd_pplv_q;
    prmd_pie_d  = prmd_pie_q;
    ecfg_lie_d  = ecfg_lie_q;
    is_sw_d     = is_sw_q;
    is_hw_d     = hw_int_in;
    is_ipi_d    = ipi_int_in;
    is_timer_d  = is_timer_q;
    ecode_d     = ecode_q;
    esubcode_d  = esubcode_q;
    era_d       = era_q;
    badv_d      = badv_q;
    eentry_d    = eentry_q;
    save_d      = save_q;
    tcfg_d      = tcfg_q;
    timer_d     = timer_q;
`ifdef CSR_TID_EN
    tid_d       = tid_q;
    if (csr.csr_we && csr.csr_num == c_addr_tid) tid_d = w_wnew;
`endif

    if (csr.csr_we && csr.csr_num == c_addr_ecfg)   ecfg_lie_d = w_wnew[12:0] & c_lie_mask;
    if (csr.csr_we && csr.csr_num == c_addr_estat)  is_sw_d    = w_wnew[1:0];
    if (csr.csr_we && csr.csr_num == c_addr_eentry) eentry_d   = w_wnew[31:6];
    if (csr.csr_we && csr.csr_num == c_addr_badv)   badv_d     = w_wnew;
    for (int i = 0; i < SAVE_NUM; i++) begin
      if (csr.csr_we && csr.csr_num == c_addr_save + 14'(i)) save_d[i] = w_wnew;
    end

    // Privilege state: exception entry beats ertn beats software write
    if (wb_ex) begin
      prmd_pplv_d = crmd_plv_q;
      prmd_pie_d  = crmd_ie_q;
      crmd_plv_d  = 2'b00;
      crmd_ie_d   = 1'b0;
      era_d       = wb_pc;
      ecode_d     = wb_ecode;
      esubcode_d  = wb_esubcode;
      if (wb_ecode == c_ecode_ade || wb_ecode == c_ecode_ale) begin
        // ADEF faults on the fetch address itself
        badv_d = (wb_ecode == c_ecode_ade && wb_esubcode == 9'd0) ? wb_pc : wb_vaddr;
      end
    end else if (eret_flush) begin
      crmd_plv_d = prmd_pplv_q;
      crmd_ie_d  = prmd_pie_q;
    end else begin
      if (csr.csr_we && csr.csr_num == c_addr_crmd) begin
        crmd_plv_d = w_wnew[1:0];
        crmd_ie_d  = w_wnew[2];
      end
      if (csr.csr_we && csr.csr_num == c_addr_prmd) begin
        prmd_pplv_d = w_wnew[1:0];
        prmd_pie_d  = w_wnew[2];
      end
      if (csr.csr_we && csr.csr_num == c_addr_era) era_d = w_wnew;
    end

    // Timer: a TCFG write overrides counting; all-ones is the parked state
    if (csr.csr_we && csr.csr_num == c_addr_tcfg) begin
      tcfg_d = w_wnew[TIMER_W-1:0];
      if (tcfg_d[0]) timer_d = {tcfg_d[TIMER_W-1:2], 2'b00};
    end else if (tcfg_q[0] && timer_q != '1) begin
      if (timer_q == '0 && tcfg_q[1]) timer_d = {tcfg_q[TIMER_W-1:2], 2'b00};
      else                            timer_d = timer_q - TIMER_W'(1);
    end

    // Timer interrupt: expiry set wins over a same-cycle clear
    if (csr.csr_we && csr.csr_num == c_addr_ticlr && w_wnew[0]) is_timer_d = 1'b0;
    if (tcfg_q[0] && timer_q == '0) is_timer_d = 1'b1;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      crmd_plv_q  <= '0;
      crmd_ie_q   <= 1'b0;
      prmd_pplv_q <= '0;
      prmd_pie_q  <= 1'b0;
      ecfg_lie_q  <= '0;
      is_sw_q     <= '0;
      is_hw_q     <= '0;
      is_timer_q  <= 1'b0;
      is_ipi_q    <= 1'b0;
      ecode_q     <= '0;
      esubcode_q  <= '0;
      era_q       <= '0;
      badv_q      <= '0;
      eentry_q    <= '0;
      for (int i = 0; i < SAVE_NUM; i++) save_q[i] <= '0;
      tcfg_q      <= '0;
      timer_q     <= '1;
`ifdef CSR_TID_EN
      tid_q       <= '0;
`endif
    end else begin
      crmd_plv_q  <= crmd_plv_d;
      crmd_ie_q   <= crmd_ie_d;
      prmd_pplv_q <= prmd_pplv_d;
      prmd_pie_q  <= prmd_pie_d;
      ecfg_lie_q  <= ecfg_lie_d;
      is_sw_q     <= is_sw_d;
      is_hw_q     <= is_hw_d;
      is_timer_q  <= is_timer_d;
      is_ipi_q    <= is_ipi_d;
      ecode_q     <= ecode_d;
      esubcode_q  <= esubcode_d;
      era_q       <= era_d;
      badv_q      <= badv_d;
      eentry_q    <= eentry_d;
      save_q      <= save_d;
      tcfg_q      <= tcfg_d;
      timer_q     <= timer_d;
`ifdef CSR_TID_EN
      tid_q       <= tid_d;
`endif
    end
  end

  assign has_int  = crmd_ie_q && |(w_is & ecfg_lie_q);
  assign ex_entry = {eentry_q, 6'b0};
  assign era_out  = era_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_csr_unit
// Description : Self-checking bench for csr_unit: directed scenarios plus
//               randomized traffic against a register-image reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_unit;
  localparam int SAVE_NUM = 4;
  localparam int HWI_NUM  = 8;
  localparam int TIMER_W  = 32;

  logic               clk = 1'b0;
  logic               reset;
  logic               wb_ex;
  logic [5:0]         wb_ecode;
  logic [8:0]         wb_esubcode;
  logic [31:0]        wb_pc;
  logic [31:0]        wb_vaddr;
  logic               eret_flush;
  logic [HWI_NUM-1:0] hw_int_in;
  logic               ipi_int_in;
  logic               has_int;
  logic [31:0]        ex_entry;
  logic [31:0]        era_out;

  csr_unit_if bus ();

  csr_unit #(.SAVE_NUM(SAVE_NUM), .HWI_NUM(HWI_NUM), .TIMER_W(TIMER_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .csr         (bus),
    .wb_ex       (wb_ex),
    .wb_ecode    (wb_ecode),
    .wb_esubcode (wb_esubcode),
    .wb_pc       (wb_pc),
    .wb_vaddr    (wb_vaddr),
    .eret_flush  (eret_flush),
    .hw_int_in   (hw_int_in),
    .ipi_int_in  (ipi_int_in),
    .has_int     (has_int),
    .ex_entry    (ex_entry),
    .era_out     (era_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: one 32-bit read image per CSR address plus the counter
  logic [31:0] m_img [0:127];
  logic [31:0] m_cnt;
  bit          m_ok = 1'b0;

  function automatic bit m_is_save(input logic [13:0] a);
    return (a >= 14'h30) && (a < 14'h30 + 14'(SAVE_NUM));
  endfunction

  // Software-writable bits of each address
  function automatic logic [31:0] m_wm(input logic [13:0] a);
    if (m_is_save(a)) return 32'hFFFF_FFFF;
    case (a)
      14'h000, 14'h001: return 32'h0000_0007;
      14'h004:          return 32'h0000_1BFF;
      14'h005:          return 32'h0000_0003;
      14'h006, 14'h007: return 32'hFFFF_FFFF;
      14'h00C:          return 32'hFFFF_FFC0;
      14'h041:          return 32'hFFFF_FFFF;
      default:          return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [13:0] a);
    if (a == 14'h042) return m_cnt;
    if (m_is_save(a)) return m_img[a[6:0]];
    case (a)
      14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007, 14'h00C, 14'h041:
        return m_img[a[6:0]];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_has_int();
    return m_img[0][2] && (|(m_img[5][12:0] & m_img[4][12:0]));
  endfunction

  // Advance the model across one rising edge using the inputs now applied
  task automatic m_step();
    logic [31:0] o [0:127];
    logic [31:0] rd, nv, wm, est, tc;
    logic [13:0] a;
    if (reset) begin
      for (int i = 0; i < 128; i++) m_img[i] = 32'h0;
      m_img[0] = 32'h8;
      m_cnt    = 32'hFFFF_FFFF;
      return;
    end
    o  = m_img;
    a  = bus.csr_num;
    rd = m_read(a);
    nv = (bus.csr_wmask & bus.csr_wvalue) | (~bus.csr_wmask & rd);
    wm = m_wm(a);
    if (bus.csr_we && wm != 0 &&
        !((a == 14'h0 || a == 14'h1 || a == 14'h6) && (wb_ex || eret_flush)))
      m_img[a[6:0]] = (nv & wm) | (o[a[6:0]] & ~wm);
    est       = m_img[5];
    est[9:2]  = hw_int_in;
    est[12]   = ipi_int_in;
    if (bus.csr_we && a == 14'h044 && nv[0]) est[11] = 1'b0;
    if (o[7'h41][0] && m_cnt == 32'h0) est[11] = 1'b1;
    if (wb_ex) begin
      m_img[1]    = o[0] & 32'h7;
      m_img[0]    = 32'h8;
      m_img[6]    = wb_pc;
      est[21:16]  = wb_ecode;
      est[30:22]  = wb_esubcode;
      if (wb_ecode == 6'h8 || wb_ecode == 6'h9)
        m_img[7] = (wb_ecode == 6'h8 && wb_esubcode == 9'd0) ? wb_pc : wb_vaddr;
    end else if (eret_flush) begin
      m_img[0] = 32'h8 | (o[1] & 32'h7);
    end
    m_img[5] = est;
    tc = m_img[7'h41];
    if (bus.csr_we && a == 14'h041) begin
      if (tc[0]) m_cnt = tc & ~32'h3;
    end else if (o[7'h41][0] && m_cnt != 32'hFFFF_FFFF) begin
      m_cnt = (m_cnt == 32'h0 && o[7'h41][1]) ? (o[7'h41] & ~32'h3) : m_cnt - 32'd1;
    end
  endtask

  // One clock: compare outputs to the model, cross the edge, update model
  task automatic tick();
    #2;
    if (m_ok) begin
      chk("rvalue", bus.csr_rvalue, bus.csr_re ? m_read(bus.csr_num) : 32'h0);
      chk("has_int", 32'(has_int), 32'(m_has_int()));
      chk("ex_entry", ex_entry, m_img[12]);
      chk("era_out", era_out, m_img[6]);
    end
    @(posedge clk);
    m_step();
    if (reset) m_ok = 1'b1;
    #1;
  endtask

  task automatic idle();
    bus.csr_re     = 1'b0;
    bus.csr_num    = 14'h0;
    bus.csr_we     = 1'b0;
    bus.csr_wmask  = 32'h0;
    bus.csr_wvalue = 32'h0;
    wb_ex          = 1'b0;
    wb_ecode       = 6'h0;
    wb_esubcode    = 9'h0;
    wb_pc          = 32'h0;
    wb_vaddr       = 32'h0;
    eret_flush     = 1'b0;
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] m, input logic [31:0] v);
    idle();
    bus.csr_we     = 1'b1;
    bus.csr_num    = a;
    bus.csr_wmask  = m;
    bus.csr_wvalue = v;
    tick();
  endtask

  task automatic rd_expect(input logic [13:0] a, input logic [31:0] exp, input string tag);
    idle();
    bus.csr_re  = 1'b1;
    bus.csr_num = a;
    #1;
    chk(tag, bus.csr_rvalue, exp);
    tick();
  endtask

  task automatic rd_bit(input logic [13:0] a, input int b, input logic e, input string tag);
    idle();
    bus.csr_re  = 1'b1;
    bus.csr_num = a;
    #1;
    chk(tag, 32'(bus.csr_rvalue[b]), 32'(e));
    tick();
  endtask

  task automatic pulse_ex(input logic [5:0] ec, input logic [8:0] esc,
                          input logic [31:0] pc, input logic [31:0] va);
    idle();
    wb_ex       = 1'b1;
    wb_ecode    = ec;
    wb_esubcode = esc;
    wb_pc       = pc;
    wb_vaddr    = va;
    tick();
  endtask

  task automatic pulse_eret();
    idle();
    eret_flush = 1'b1;
    tick();
  endtask

  logic [13:0] addr_tab [16] = '{14'h000, 14'h001, 14'h004, 14'h005, 14'h006, 14'h007,
                                 14'h00C, 14'h030, 14'h031, 14'h032, 14'h033, 14'h034,
                                 14'h040, 14'h041, 14'h042, 14'h044};

  initial begin
    idle();
    hw_int_in  = '0;
    ipi_int_in = 1'b0;
    reset      = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    // Reset state
    rd_expect(14'h000, 32'h0000_0008, "reset_crmd");
    rd_expect(14'h042, 32'hFFFF_FFFF, "reset_tval");
    chk("reset_has_int", 32'(has_int), 32'h0);
    chk("reset_ex_entry", ex_entry, 32'h0);

    // Masked write and unmapped addresses
    wr(14'h032, 32'hFFFF_FFFF, 32'hAAAA_AAAA);
    wr(14'h032, 32'h0000_FFFF, 32'h1234_5678);
    rd_expect(14'h032, 32'hAAAA_5678, "save2_masked");
    wr(14'h034, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    rd_expect(14'h034, 32'h0, "save_beyond_num");
    wr(14'h040, 32'hFFFF_FFFF, 32'hCAFE_F00D);
    rd_expect(14'h040, 32'h0, "tid_absent");
    wr(14'h00C, 32'hFFFF_FFFF, 32'h1C00_8FFF);
    chk("eentry_out", ex_entry, 32'h1C00_8FC0);

    // Exception entry and return
    wr(14'h000, 32'hFFFF_FFFF, 32'h0000_0007);
    rd_expect(14'h000, 32'h0000_000F, "crmd_set");
    pulse_ex(6'h9, 9'h0, 32'h1C00_0100, 32'h8000_0003);
    rd_expect(14'h000, 32'h0000_0008, "ex_crmd");
    rd_expect(14'h001, 32'h0000_0007, "ex_prmd");
    rd_expect(14'h006, 32'h1C00_0100, "ex_era");
    rd_expect(14'h007, 32'h8000_0003, "ex_badv_ale");
    rd_expect(14'h005, 32'h0009_0000, "ex_estat");
    chk("era_out", era_out, 32'h1C00_0100);
    pulse_eret();
    rd_expect(14'h000, 32'h0000_000F, "eret_crmd");
    pulse_ex(6'h8, 9'h0, 32'h1C00_0200, 32'h1234_5678);
    rd_expect(14'h007, 32'h1C00_0200, "ex_badv_adef");
    pulse_eret();

    // Periodic timer
    wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0800);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0013);
    for (int k = 0; k < 18; k++)
      rd_expect(14'h042, (k <= 16) ? 32'(16 - k) : 32'd16, "tval_periodic");
    chk("timer_has_int", 32'(has_int), 32'h1);
    wr(14'h044, 32'h0000_0001, 32'h0000_0001);
    chk("ticlr_has_int", 32'(has_int), 32'h0);

    // One-shot timer
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0000);
    wr(14'h044, 32'hFFFF_FFFF, 32'h0000_0001);
    wr(14'h041, 32'hFFFF_FFFF, 32'h0000_0009);
    for (int k = 0; k < 12; k++)
      rd_expect(14'h042, (k <= 8) ? 32'(8 - k) : 32'hFFFF_FFFF, "tval_oneshot");
    rd_bit(14'h005, 11, 1'b1, "oneshot_is11_set");
    wr(14'h044, 32'hFFFF_FFFF, 32'h0000_0001);
    for (int k = 0; k < 3; k++) rd_bit(14'h005, 11, 1'b0, "oneshot_is11_once");

    // Hardware interrupt, then exception and TCFG write together
    wr(14'h004, 32'hFFFF_FFFF, 32'h0000_0004);
    hw_int_in = 8'h01;
    idle();
    tick();
    chk("hwi_has_int", 32'(has_int), 32'h1);
    rd_bit(14'h005, 2, 1'b1, "hwi_is2");
    idle();
    wb_ex          = 1'b1;
    wb_ecode       = 6'h3;
    wb_pc          = 32'h1C00_0400;
    bus.csr_we     = 1'b1;
    bus.csr_num    = 14'h041;
    bus.csr_wmask  = 32'hFFFF_FFFF;
    bus.csr_wvalue = 32'h0000_0013;
    tick();
    rd_expect(14'h042, 32'd16, "combo_tval");
    rd_expect(14'h000, 32'h0000_0008, "combo_crmd");
    rd_expect(14'h006, 32'h1C00_0400, "combo_era");
    chk("combo_has_int", 32'(has_int), 32'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      idle();
      bus.csr_re  = 1'($urandom_range(1, 0));
      bus.csr_num = ($urandom_range(7, 0) == 0) ? 14'($urandom) : addr_tab[$urandom_range(15, 0)];
      bus.csr_we  = ($urandom_range(2, 0) == 0);
      bus.csr_wmask  = $urandom_range(1, 0) ? 32'hFFFF_FFFF : $urandom;
      bus.csr_wvalue = $urandom;
      if (bus.csr_num == 14'h041) bus.csr_wvalue = bus.csr_wvalue & 32'h3F;
      wb_ex = ($urandom_range(15, 0) == 0);
      case ($urandom_range(2, 0))
        0:       wb_ecode = 6'h8;
        1:       wb_ecode = 6'h9;
        default: wb_ecode = 6'($urandom);
      endcase
      wb_esubcode = ($urandom_range(3, 0) == 0) ? 9'h0 : 9'($urandom);
      wb_pc       = $urandom;
      wb_vaddr    = $urandom;
      eret_flush  = ($urandom_range(11, 0) == 0);
      if (eret_flush && (bus.csr_num == 14'h0 || bus.csr_num == 14'h1 || bus.csr_num == 14'h6))
        bus.csr_we = 1'b0;
      if ($urandom_range(3, 0) == 0) hw_int_in = HWI_NUM'($urandom);
      if ($urandom_range(3, 0) == 0) ipi_int_in = 1'($urandom_range(1, 0));
      tick();
    end

    // Reset dominates same-cycle write and exception
    idle();
    hw_int_in      = '0;
    ipi_int_in     = 1'b0;
    reset          = 1'b1;
    wb_ex          = 1'b1;
    wb_pc          = 32'h1C00_0800;
    bus.csr_we     = 1'b1;
    bus.csr_num    = 14'h030;
    bus.csr_wmask  = 32'hFFFF_FFFF;
    bus.csr_wvalue = 32'h5555_5555;
    tick();
    reset = 1'b0;
    rd_expect(14'h000, 32'h0000_0008, "rst_dom_crmd");
    rd_expect(14'h030, 32'h0, "rst_dom_save0");
    rd_expect(14'h006, 32'h0, "rst_dom_era");
    rd_expect(14'h042, 32'hFFFF_FFFF, "rst_dom_tval");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
